// File: rtl/isp_video_src.sv
// Raster test-pattern source: vsync/hsync/pixel stream with programmable blanking.
module isp_video_src #(
   parameter int unsigned BITS    = 8,
   parameter int unsigned WIDTH   = 960,
   parameter int unsigned HEIGHT  = 540,
   parameter int unsigned HBLANK  = 64,
   parameter int unsigned VSYNC_W = 16,
   parameter int unsigned VBP     = 32,
   parameter int unsigned VFP     = 2048
) (
   input  logic            clock,
   input  logic            rst_n,
   input  logic            enable,
   input  logic [1:0]      pattern_sel,
   input  logic [BITS-1:0] cfg_const,
   output logic            out_vsync,
   output logic            out_hsync,
   output logic [BITS-1:0] out_data,
   output logic            frame_done,
   output logic [15:0]     frame_cnt,
   output logic            busy
);

   localparam int unsigned CW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int unsigned RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int unsigned PMAX_A = (VFP > HBLANK)  ? VFP : HBLANK;
   localparam int unsigned PMAX_B = (VBP > VSYNC_W) ? VBP : VSYNC_W;
   localparam int unsigned PMAX   = (PMAX_A > PMAX_B) ? PMAX_A : PMAX_B;
   localparam int unsigned PW     = $clog2(PMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_HBLANK, S_VFP
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   logic [1:0]      pat_q, pat_d;
   logic [BITS-1:0] const_q, const_d;
   logic            vsync_q, vsync_d;
   logic            hsync_q, hsync_d;
   logic [BITS-1:0] data_q, data_d;
   logic            done_q, done_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            busy_q, busy_d;

   // Next state, raster counters, and registered-output values derived from the next state
   always_comb begin
      state_d = state_q;
      phase_d = phase_q + PW'(1);
      col_d   = col_q;
      row_d   = row_q;
      pat_d   = pat_q;
      const_d = const_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      vsync_d = 1'b1;
      hsync_d = 1'b0;
      busy_d  = 1'b0;
      data_d  = '0;

      case (state_q)
         S_IDLE: begin
            phase_d = '0;
            if (enable) begin
               state_d = S_VSYNC;
               pat_d   = pattern_sel;
               const_d = cfg_const;
               col_d   = '0;
               row_d   = '0;
            end
         end
         S_VSYNC: begin
            if (phase_q == PW'(VSYNC_W - 1)) begin
               state_d = S_VBP;
               phase_d = '0;
            end
         end
         S_VBP: begin
            if (phase_q == PW'(VBP - 1)) begin
               state_d = S_ACTIVE;
               phase_d = '0;
               col_d   = '0;
            end
         end
         S_ACTIVE: begin
            phase_d = '0;
            if (col_q == CW'(WIDTH - 1)) begin
               col_d   = '0;
               state_d = (row_q == RW'(HEIGHT - 1)) ? S_VFP : S_HBLANK;
            end else begin
               col_d = col_q + CW'(1);
            end
         end
         S_HBLANK: begin
            if (phase_q == PW'(HBLANK - 1)) begin
               state_d = S_ACTIVE;
               phase_d = '0;
               row_d   = row_q + RW'(1);
            end
         end
         S_VFP: begin
            if (phase_q == PW'(VFP - 1)) begin
               phase_d = '0;
               if (enable) begin
                  state_d = S_VSYNC;
                  pat_d   = pattern_sel;
                  const_d = cfg_const;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            phase_d = '0;
         end
      endcase

      // Last VFP cycle: pulse done, count the frame, clear raster position
      if (state_d == S_VFP && phase_d == PW'(VFP - 1)) begin
         done_d = 1'b1;
         cnt_d  = cnt_q + 16'd1;
         col_d  = '0;
         row_d  = '0;
      end

      vsync_d = (state_d == S_IDLE) || (state_d == S_VSYNC);
      hsync_d = (state_d == S_ACTIVE);
      busy_d  = (state_d != S_IDLE);

      if (hsync_d) begin
         case (pat_d)
            2'd0:    data_d = BITS'(col_d);
            2'd1:    data_d = BITS'(row_d);
            2'd2:    data_d = ((((32'(col_d) >> 3) ^ (32'(row_d) >> 3)) & 32'd1) != 32'd0) ? '1 : '0;
            default: data_d = const_d;
         endcase
      end
   end

   // State, counters and output registers
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         phase_q <= '0;
         col_q   <= '0;
         row_q   <= '0;
         pat_q   <= '0;
         const_q <= '0;
         vsync_q <= 1'b1;
         hsync_q <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         col_q   <= col_d;
         row_q   <= row_d;
         pat_q   <= pat_d;
         const_q <= const_d;
         vsync_q <= vsync_d;
         hsync_q <= hsync_d;
         data_q  <= data_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   assign out_vsync  = vsync_q;
   assign out_hsync  = hsync_q;
   assign out_data   = data_q;
   assign frame_done = done_q;
   assign frame_cnt  = cnt_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_isp_video_src.sv
// Directed bench for isp_video_src: timing checks plus a pixel scoreboard.
module tb_isp_video_src;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int HB = 3;
   localparam int VW = 2;
   localparam int VB = 4;
   localparam int VF = 100;
   localparam int T  = VW + VB + H * W + (H - 1) * HB + VF;
   localparam int W2 = 16;
   localparam int H2 = 16;
   localparam int T2 = VW + VB + H2 * W2 + (H2 - 1) * HB + VF;

   logic        clock = 1'b0;
   logic        rst_n;
   logic        enable, enable_b;
   logic [1:0]  pattern_sel;
   logic [7:0]  cfg_const;
   logic        out_vsync, out_hsync, frame_done, busy;
   logic [7:0]  out_data;
   logic [15:0] frame_cnt;
   logic        vsync_b, hsync_b, done_b, busy_b;
   logic [7:0]  data_b;
   logic [15:0] cnt_b;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int e, eb;

   logic [7:0] sbq[$];
   logic [7:0] qb[$];
   int         hs_rise[$];
   int         hs_fall[$];
   logic       hs_prev = 1'b0;

   isp_video_src #(.BITS(8), .WIDTH(W), .HEIGHT(H), .HBLANK(HB), .VSYNC_W(VW), .VBP(VB), .VFP(VF)) dut (
      .clock(clock), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel), .cfg_const(cfg_const),
      .out_vsync(out_vsync), .out_hsync(out_hsync), .out_data(out_data),
      .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy));

   isp_video_src #(.BITS(8), .WIDTH(W2), .HEIGHT(H2), .HBLANK(HB), .VSYNC_W(VW), .VBP(VB), .VFP(VF)) dut_b (
      .clock(clock), .rst_n(rst_n), .enable(enable_b), .pattern_sel(2'd2), .cfg_const(8'h00),
      .out_vsync(vsync_b), .out_hsync(hsync_b), .out_data(data_b),
      .frame_done(done_b), .frame_cnt(cnt_b), .busy(busy_b));

   always #5 clock = ~clock;

   // Cycle index: after active edge n, cyc == n
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pix(input int pat, input int r, input int c, input logic [7:0] k);
      case (pat)
         0:       pix = 8'(c);
         1:       pix = 8'(r);
         2:       pix = ((((c / 8) + (r / 8)) % 2) == 1) ? 8'hFF : 8'h00;
         default: pix = k;
      endcase
   endfunction

   task automatic push_frame_a(input int pat, input logic [7:0] k);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) sbq.push_back(pix(pat, r, c, k));
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clock);
   endtask

   task automatic check_lines(input int f);
      check("hs_rise_count", 32'(hs_rise.size()), 32'(H));
      check("hs_fall_count", 32'(hs_fall.size()), 32'(H));
      for (int k = 0; k < H; k++) begin
         if (hs_rise.size() > 0) check("hs_rise_time", 32'(hs_rise.pop_front()), 32'(f + VW + VB + k * (W + HB)));
         if (hs_fall.size() > 0) check("hs_fall_time", 32'(hs_fall.pop_front()), 32'(f + VW + VB + k * (W + HB) + W));
      end
      hs_rise.delete();
      hs_fall.delete();
   endtask

   // Main-DUT monitor: pixel scoreboard, blank data, hsync edge times
   always @(negedge clock) begin
      logic [7:0] exp_px;
      if (out_hsync) begin
         checks++;
         assert (sbq.size() > 0) else begin
            errors++;
            $error("FAIL sb_underrun_a observed=pixel_at_cyc_%0d expected=no_hsync", cyc);
         end
         if (sbq.size() > 0) begin
            exp_px = sbq.pop_front();
            check("pix_a", 32'(out_data), 32'(exp_px));
         end
      end else begin
         check("blank_data_a", 32'(out_data), 32'd0);
      end
      if (out_hsync && !hs_prev) hs_rise.push_back(cyc);
      if (!out_hsync && hs_prev) hs_fall.push_back(cyc);
      hs_prev <= out_hsync;
   end

   // Checker-DUT monitor: pixel scoreboard
   always @(negedge clock) begin
      logic [7:0] exp_px;
      if (hsync_b) begin
         checks++;
         assert (qb.size() > 0) else begin
            errors++;
            $error("FAIL sb_underrun_b observed=pixel_at_cyc_%0d expected=no_hsync", cyc);
         end
         if (qb.size() > 0) begin
            exp_px = qb.pop_front();
            check("pix_b", 32'(data_b), 32'(exp_px));
         end
      end
   end

   initial begin
      rst_n = 1'b0; enable = 1'b0; enable_b = 1'b0; pattern_sel = 2'd0; cfg_const = 8'h00;
      repeat (3) @(negedge clock);
      check("rst_vsync", 32'(out_vsync), 32'd1);
      check("rst_hsync", 32'(out_hsync), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
      check("rst_cnt", 32'(frame_cnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clock);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_vsync", 32'(out_vsync), 32'd1);

      // Three back-to-back frames: h-ramp, v-ramp, constant; mid-frame changes ignored
      enable = 1'b1; pattern_sel = 2'd0; cfg_const = 8'h3C; e = cyc + 1;
      push_frame_a(0, 8'h00); push_frame_a(1, 8'h00); push_frame_a(3, 8'hA5);
      wait_until(e);        check("f1_busy", 32'(busy), 32'd1); check("f1_vs_e", 32'(out_vsync), 32'd1);
      wait_until(e + 1);    check("f1_vs_e1", 32'(out_vsync), 32'd1);
      wait_until(e + 2);    check("f1_vs_fall", 32'(out_vsync), 32'd0);
      wait_until(e + 5);    check("f1_hs_pre", 32'(out_hsync), 32'd0);
      wait_until(e + 6);    check("f1_hs_rise", 32'(out_hsync), 32'd1); check("f1_d0", 32'(out_data), 32'd0);
      wait_until(e + 20);   pattern_sel = 2'd1;
      wait_until(e + T - 2); check("f1_done_pre", 32'(frame_done), 32'd0);
      wait_until(e + T - 1); check("f1_done", 32'(frame_done), 32'd1); check("f1_cnt", 32'(frame_cnt), 32'd1);
      check_lines(e);
      wait_until(e + T);    check("f2_done_clr", 32'(frame_done), 32'd0); check("f2_vs_rise", 32'(out_vsync), 32'd1);
      check("f2_busy", 32'(busy), 32'd1);
      wait_until(e + T + 2); check("f2_vs_fall", 32'(out_vsync), 32'd0);
      wait_until(e + T + 20); pattern_sel = 2'd3; cfg_const = 8'hA5;
      wait_until(e + 2 * T - 1); check("f2_done", 32'(frame_done), 32'd1); check("f2_cnt", 32'(frame_cnt), 32'd2);
      check_lines(e + T);
      wait_until(e + 2 * T); check("f3_vs_rise", 32'(out_vsync), 32'd1);
      wait_until(e + 2 * T + 20); cfg_const = 8'h11; pattern_sel = 2'd0;
      wait_until(e + 2 * T + VW + VB + W + HB + 2); enable = 1'b0;
      wait_until(e + 3 * T - 1); check("f3_done", 32'(frame_done), 32'd1); check("f3_cnt", 32'(frame_cnt), 32'd3);
      check_lines(e + 2 * T);
      wait_until(e + 3 * T); check("stop_busy", 32'(busy), 32'd0); check("stop_vsync", 32'(out_vsync), 32'd1);
      check("stop_hsync", 32'(out_hsync), 32'd0); check("stop_done", 32'(frame_done), 32'd0);
      wait_until(e + 3 * T + 5); check("stop_idle", 32'(busy), 32'd0);
      check("sb_drained_a", 32'(sbq.size()), 32'd0);

      // Reset during line 2, col 5
      enable = 1'b1; pattern_sel = 2'd0; e = cyc + 1;
      push_frame_a(0, 8'h00);
      wait_until(e + VW + VB + 2 * (W + HB) + 5);
      check("pre_rst_hsync", 32'(out_hsync), 32'd1); check("pre_rst_data", 32'(out_data), 32'd5);
      rst_n = 1'b0; enable = 1'b0;
      #1;
      check("mid_rst_vsync", 32'(out_vsync), 32'd1);
      check("mid_rst_hsync", 32'(out_hsync), 32'd0);
      check("mid_rst_data", 32'(out_data), 32'd0);
      check("mid_rst_cnt", 32'(frame_cnt), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      sbq.delete(); hs_rise.delete(); hs_fall.delete();
      repeat (3) @(negedge clock);
      check("post_rst_busy", 32'(busy), 32'd0); check("post_rst_hsync", 32'(out_hsync), 32'd0);

      // Restart with v-ramp; single frame
      enable = 1'b1; pattern_sel = 2'd1; e = cyc + 1;
      push_frame_a(1, 8'h00);
      wait_until(e);     check("rs_busy", 32'(busy), 32'd1);
      wait_until(e + 1); check("rs_vs_e1", 32'(out_vsync), 32'd1);
      wait_until(e + 2); check("rs_vs_fall", 32'(out_vsync), 32'd0);
      wait_until(e + 5); check("rs_hs_pre", 32'(out_hsync), 32'd0);
      wait_until(e + 6); check("rs_hs_rise", 32'(out_hsync), 32'd1);
      wait_until(e + 10); enable = 1'b0;
      wait_until(e + T - 1); check("rs_done", 32'(frame_done), 32'd1); check("rs_cnt", 32'(frame_cnt), 32'd1);
      check_lines(e);
      wait_until(e + T); check("rs_idle_busy", 32'(busy), 32'd0); check("rs_idle_vsync", 32'(out_vsync), 32'd1);
      check("sb_drained_rs", 32'(sbq.size()), 32'd0);

      // 16x16 checkerboard on the second instance
      enable_b = 1'b1; eb = cyc + 1;
      for (int r = 0; r < H2; r++)
         for (int c = 0; c < W2; c++) qb.push_back(pix(2, r, c, 8'h00));
      wait_until(eb); enable_b = 1'b0;
      wait_until(eb + VW + VB); check("chk_hs_rise", 32'(hsync_b), 32'd1); check("chk_d00", 32'(data_b), 32'd0);
      wait_until(eb + VW + VB + 8); check("chk_d0_8", 32'(data_b), 32'hFF);
      wait_until(eb + T2 - 1); check("chk_done", 32'(done_b), 32'd1); check("chk_cnt", 32'(cnt_b), 32'd1);
      wait_until(eb + T2); check("chk_idle", 32'(busy_b), 32'd0); check("chk_vsync", 32'(vsync_b), 32'd1);
      check("sb_drained_b", 32'(qb.size()), 32'd0);
      check("a_cnt_kept", 32'(frame_cnt), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
